xor3_vector_checker: RTL

Self-checking stimulus stage that sits directly upstream of the 3-input XOR gate and consumes its output. On a start pulse it steps `{a,b,c}` through all eight input combinations, from 000 to 111. It holds each vector for a programmable number of cycles and samples the gate output at the end of each hold window. Each sample is compared against the expected odd parity; at the end the block reports an error count and a pass flag. This replaces open-loop `#10` stimulus with a synthesizable, clocked checker.

---
 rtl/xor3_chk_pkg.sv | 19 +
 rtl/xor3_vector_checker.sv | 88 ++++++++
 2 files changed

// File: rtl/xor3_chk_pkg.sv
// Shared types and constants for the 3-input XOR gate vector checker.
// Latency: none (declarations only).
// Backpressure: not applicable.
package xor3_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int         NUM_VECTORS = 8;
   localparam logic [2:0] LAST_IDX    = 3'(NUM_VECTORS - 1);

   function automatic logic exp_parity(input logic [2:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/xor3_vector_checker.sv
// Steps {a,b,c} through 000..111, samples dut_out at the end of each hold window, counts parity mismatches.
// Latency: done asserts exactly 8*HOLD_CYCLES cycles after the edge that accepts start.
// Backpressure: none; start is accepted only in IDLE/DONE and ignored while a run is in progress.
module xor3_vector_checker
   import xor3_chk_pkg::*;
#(
   parameter int HOLD_CYCLES = 10,
   parameter int HOLD_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       dut_out,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic [2:0] vec_idx,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_count
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   state_t            state, state_n;
   logic [2:0]        vec_n;
   logic [HOLD_W-1:0] hold, hold_n;
   logic [3:0]        err_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         vec_idx   <= 3'd0;
         hold      <= '0;
         err_count <= 4'd0;
      end else begin
         state     <= state_n;
         vec_idx   <= vec_n;
         hold      <= hold_n;
         err_count <= err_n;
      end
   end

   always_comb begin
      state_n = state;
      vec_n   = vec_idx;
      hold_n  = hold;
      err_n   = err_count;
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n = DRIVE;
               vec_n   = 3'd0;
               hold_n  = '0;
               err_n   = 4'd0;
            end
         end
         DRIVE: begin
            if (hold == HOLD_LAST) begin
               // End of the hold window: the gate has had the full window to settle.
               if (dut_out != exp_parity(vec_idx)) begin
                  err_n = err_count + 4'd1;
               end
               hold_n = '0;
               if (vec_idx == LAST_IDX) begin
                  state_n = DONE;
               end else begin
                  vec_n = vec_idx + 3'd1;
               end
            end else begin
               hold_n = hold + HOLD_ONE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Gate inputs come straight from the index flops so each window sees one clean vector.
   assign {a, b, c} = vec_idx;
   assign busy      = (state == DRIVE);
   assign done      = (state == DONE);
   assign pass      = done && (err_count == 4'd0);

endmodule
